// File: rtl/opl_timer_pkg.sv
// -----------------------------------------------------------------------------
// opl_timer_pkg
// Shared constants, types and helpers for the OPL-style timer bank.
//   ACC_W      : width of each timer's fractional phase accumulator
//   MAX_TIMERS : largest supported timer count (sizes the rate helper input)
//   RATE_W     : width of one packed TICK_HZ entry
//   timer_mode_e : auto-reload or one-shot behaviour after overflow
//   tick_hz_at : extracts the base tick rate of timer idx from the packed list
// -----------------------------------------------------------------------------
package opl_timer_pkg;

    localparam int unsigned ACC_W      = 32;
    localparam int          MAX_TIMERS = 8;
    localparam int          RATE_W     = 16;

    typedef enum logic {
        MODE_RELOAD  = 1'b0,
        MODE_ONESHOT = 1'b1
    } timer_mode_e;

    // Rates are packed with timer 0 in the least significant entry.
    function automatic logic [RATE_W-1:0] tick_hz_at(
        input logic [MAX_TIMERS*RATE_W-1:0] rates,
        input int                           idx
    );
        return rates[idx*RATE_W +: RATE_W];
    endfunction

endpackage

// File: rtl/opl_timer_chan.sv
// -----------------------------------------------------------------------------
// opl_timer_chan
// One interval timer: fractional phase accumulator producing the base tick,
// up-counter with programmable preset, run enable, reload/one-shot mode and
// the registered one-cycle overflow pulse.
//
// Parameters:
//   CLK_HZ   : system clock frequency in Hz
//   CNT_W    : counter/preset width
//   TICK     : base tick rate of this timer in Hz
//   READBACK : 1 drives the live counter on 'counter', 0 ties it to zero
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   preset_we     : preset write strobe for this timer
//   preset_data   : preset value
//   ctrl_wr       : non-clear control write strobe
//   ctrl_start    : run enable latched on ctrl_wr
//   ctrl_oneshot  : one-shot mode latched on ctrl_wr
//   ovf_event     : combinational, high in the cycle of the overflow tick
//   ovf_pulse     : registered overflow pulse, one cycle after ovf_event
//   counter       : counter value (or zero when READBACK is 0)
// -----------------------------------------------------------------------------
module opl_timer_chan
    import opl_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned CNT_W    = 8,
    parameter logic [15:0] TICK     = 16'd3125,
    parameter bit          READBACK = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             preset_we,
    input  logic [CNT_W-1:0] preset_data,
    input  logic             ctrl_wr,
    input  logic             ctrl_start,
    input  logic             ctrl_oneshot,
    output logic             ovf_event,
    output logic             ovf_pulse,
    output logic [CNT_W-1:0] counter
);

    localparam logic [ACC_W:0]   CLK_LIM = (ACC_W+1)'(CLK_HZ);
    localparam logic [ACC_W-1:0] CLK_SUB = ACC_W'(CLK_HZ);
    localparam logic [ACC_W:0]   STEP    = (ACC_W+1)'(TICK);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic             active;
    timer_mode_e      mode;

    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_next;
    logic             tick;

    // The accumulator stays below CLK_HZ, so the wrapped difference always
    // fits in ACC_W bits; the extra sum bit only matters for the compare.
    always_comb begin
        acc_sum   = {1'b0, acc} + STEP;
        tick      = active && (acc_sum >= CLK_LIM);
        acc_next  = tick ? (acc_sum[ACC_W-1:0] - CLK_SUB) : acc_sum[ACC_W-1:0];
        ovf_event = tick && (cnt == CNT_MAX);
    end

    // Start edge (active 0->1) only happens when the timer is idle, so it
    // never collides with the running update. A control write while running
    // with start=1 leaves the timer running, even if a one-shot overflow
    // would otherwise stop it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preset    <= '0;
            cnt       <= '0;
            acc       <= '0;
            active    <= 1'b0;
            mode      <= MODE_RELOAD;
            ovf_pulse <= 1'b0;
        end else begin
            ovf_pulse <= ovf_event;

            if (active) begin
                acc <= acc_next;
                if (tick) begin
                    if (cnt == CNT_MAX) begin
                        cnt <= preset;
                        if (mode == MODE_ONESHOT) begin
                            active <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            if (ctrl_wr) begin
                active <= ctrl_start;
                mode   <= ctrl_oneshot ? MODE_ONESHOT : MODE_RELOAD;
                if (ctrl_start && !active) begin
                    cnt <= preset;
                    acc <= '0;
                end
            end

            if (preset_we) begin
                preset <= preset_data;
            end
        end
    end

    assign counter = READBACK ? cnt : '0;

endmodule

// File: rtl/opl_timer_bank.sv
// -----------------------------------------------------------------------------
// opl_timer_bank
// Bank of NUM_TIMERS OPL-style interval timers with sticky flags, per-timer
// IRQ masks and a shared active-low interrupt.
//
// Optional feature: define OPL_TIMER_READBACK_EN to expose each timer's live
// counter on cnt_rd (timer i at [CNT_W*i +: CNT_W]); otherwise cnt_rd is 0.
//
// Parameters: CLK_HZ, NUM_TIMERS (1..8), CNT_W (2..16), TICK_HZ (packed
//             16-bit rates, timer i at [16i+15:16i]).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   preset_we     : per-timer preset write strobes, preset_data shared
//   ctrl_we       : control write strobe
//   ctrl_clr      : with ctrl_we, clears flags and releases irq_n
//   ctrl_start    : with ctrl_we & !ctrl_clr, run enables
//   ctrl_mask     : with ctrl_we & !ctrl_clr, IRQ masks (1 = masked)
//   ctrl_oneshot  : with ctrl_we & !ctrl_clr, one-shot modes
//   ovf_pulse     : one-cycle overflow pulses
//   flag          : sticky overflow flags (set regardless of mask)
//   any_flag      : OR of flag
//   irq_n         : active-low interrupt
//   cnt_rd        : packed live counters (readback build only)
// -----------------------------------------------------------------------------
module opl_timer_bank
    import opl_timer_pkg::*;
#(
    parameter int unsigned                 CLK_HZ     = 50000000,
    parameter int unsigned                 NUM_TIMERS = 2,
    parameter int unsigned                 CNT_W      = 8,
    parameter logic [NUM_TIMERS*16-1:0]    TICK_HZ    = {16'd3125, 16'd12500}
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_TIMERS-1:0]       preset_we,
    input  logic [CNT_W-1:0]            preset_data,
    input  logic                        ctrl_we,
    input  logic                        ctrl_clr,
    input  logic [NUM_TIMERS-1:0]       ctrl_start,
    input  logic [NUM_TIMERS-1:0]       ctrl_mask,
    input  logic [NUM_TIMERS-1:0]       ctrl_oneshot,
    output logic [NUM_TIMERS-1:0]       ovf_pulse,
    output logic [NUM_TIMERS-1:0]       flag,
    output logic                        any_flag,
    output logic                        irq_n,
    output logic [NUM_TIMERS*CNT_W-1:0] cnt_rd
);

`ifdef OPL_TIMER_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    localparam logic [MAX_TIMERS*RATE_W-1:0] TICK_ALL = (MAX_TIMERS*RATE_W)'(TICK_HZ);

    logic                        ctrl_wr;
    logic                        clr_wr;
    logic [NUM_TIMERS-1:0]       ovf_event;
    logic [NUM_TIMERS-1:0]       mask;
    logic                        irq_pend;
    logic [NUM_TIMERS*CNT_W-1:0] cnt_all;

    assign ctrl_wr = ctrl_we && !ctrl_clr;
    assign clr_wr  = ctrl_we && ctrl_clr;

    for (genvar g = 0; g < int'(NUM_TIMERS); g++) begin : g_chan
        opl_timer_chan #(
            .CLK_HZ   (CLK_HZ),
            .CNT_W    (CNT_W),
            .TICK     (tick_hz_at(TICK_ALL, g)),
            .READBACK (READBACK)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .preset_we    (preset_we[g]),
            .preset_data  (preset_data),
            .ctrl_wr      (ctrl_wr),
            .ctrl_start   (ctrl_start[g]),
            .ctrl_oneshot (ctrl_oneshot[g]),
            .ovf_event    (ovf_event[g]),
            .ovf_pulse    (ovf_pulse[g]),
            .counter      (cnt_all[g*CNT_W +: CNT_W])
        );
    end

    // A clear and an overflow in the same cycle: the overflow wins, so the
    // new event is ORed in after the clear. The IRQ uses the mask in force
    // at the overflow; later mask writes never release a pending IRQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag     <= '0;
            mask     <= '0;
            irq_pend <= 1'b0;
        end else begin
            flag <= (clr_wr ? '0 : flag) | ovf_event;
            if (clr_wr) begin
                irq_pend <= |(ovf_event & ~mask);
            end else begin
                irq_pend <= irq_pend | (|(ovf_event & ~mask));
            end
            if (ctrl_wr) begin
                mask <= ctrl_mask;
            end
        end
    end

    assign any_flag = |flag;
    assign irq_n    = !irq_pend;
    assign cnt_rd   = cnt_all;

endmodule
